// File: rtl/udi_mag_cmp_pipe.sv
// M14K UDI payload: squared magnitude of the upper operand halves, compared against a threshold
// bank and summed into a saturating energy accumulator, with a LAT-cycle result latency.
module udi_mag_cmp_pipe #(
  parameter int OPW  = 16,
  parameter int NTHR = 4,
  parameter int LAT  = 2
) (
  input  logic        UDI_gclk,
  input  logic        UDI_greset_n,
  input  logic [31:0] UDI_ir_e,
  input  logic        UDI_irvalid_e,
  input  logic [31:0] UDI_rs_e,
  input  logic [31:0] UDI_rt_e,
  input  logic        UDI_start_e,
  input  logic        UDI_kill_m,
  input  logic        UDI_run_m,
  output logic [31:0] UDI_rd_m,
  output logic [4:0]  UDI_wrreg_e,
  output logic        UDI_ri_e,
  output logic        UDI_stall_m,
  output logic        UDI_present,
  output logic        UDI_honor_cee
);

  localparam int IW = (NTHR > 1) ? $clog2(NTHR) : 1;

  localparam logic [5:0] F_SUM   = 6'd16;
  localparam logic [5:0] F_SUMSH = 6'd17;
  localparam logic [5:0] F_SQ    = 6'd18;
  localparam logic [5:0] F_WRTHR = 6'd19;
  localparam logic [5:0] F_CMPS  = 6'd20;
  localparam logic [5:0] F_CMPH  = 6'd21;
  localparam logic [5:0] F_CMPQ  = 6'd22;
  localparam logic [5:0] F_ACC   = 6'd23;
  localparam logic [5:0] F_RDCLR = 6'd24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] sat32(input logic [33:0] v);
    if (v[33:32] != 2'b00) begin
      sat32 = 32'hFFFF_FFFF;
    end else begin
      sat32 = v[31:0];
    end
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     rs_q, rs_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [31:0]     rd_m_q, rd_m_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     thr_q [NTHR];
  logic [31:0]     thr_d [NTHR];

  logic [5:0]      funct_s;
  logic            major_s, legal_s, kill_s, issue_s, finish_s, commit_s;
  logic [IW-1:0]   idx_e_s, src_idx_s;
  logic [5:0]      src_op_s;
  logic [OPW-1:0]  src_a_s, src_b_s;
  logic [33:0]     aa_s, bb_s, s_wide_s;
  logic [32:0]     acc_sum_s;
  logic [31:0]     sum32_s, sumsh_s, sq_s, thr_sel_s, result_s;
  logic            unused_s;

  assign funct_s       = UDI_ir_e[5:0];
  assign major_s       = (UDI_ir_e[31:26] == 6'd28);
  assign legal_s       = (funct_s >= F_SUM) && (funct_s <= F_RDCLR);
  assign kill_s        = UDI_kill_m & UDI_run_m;
  assign UDI_present   = 1'b1;
  assign UDI_honor_cee = 1'b1;
  assign UDI_rd_m      = rd_m_q;
  assign UDI_stall_m   = (state_q == S_BUSY) & ~kill_s;
  assign unused_s      = ^{UDI_rt_e[31-OPW:0], UDI_ir_e[25:16], UDI_ir_e[10:6]};

  // Instruction decode in E: reserved-instruction flag, destination register, issue qualifier.
  always_comb begin
    UDI_ri_e    = UDI_irvalid_e & major_s & (funct_s[5:4] == 2'b01) & ~legal_s;
    UDI_wrreg_e = (funct_s == F_WRTHR) ? 5'd0 : UDI_ir_e[15:11];
    if (NTHR == 1) begin
      idx_e_s = '0;
    end else begin
      idx_e_s = UDI_ir_e[6 +: IW];
    end
    // A killed M op frees the unit in the same cycle only when there is no busy period.
    issue_s = UDI_irvalid_e & UDI_start_e & major_s & legal_s &
              ((state_q == S_IDLE) | ((LAT == 1) & (state_q == S_DONE) & kill_s));
  end

  // Datapath: with LAT=1 the result is formed straight from the E operands.
  always_comb begin
    if (LAT == 1) begin
      src_op_s  = funct_s;
      src_idx_s = idx_e_s;
      src_a_s   = UDI_rs_e[31 -: OPW];
      src_b_s   = UDI_rt_e[31 -: OPW];
    end else begin
      src_op_s  = op_q;
      src_idx_s = idx_q;
      src_a_s   = rs_q[31 -: OPW];
      src_b_s   = b_q;
    end
    aa_s      = 34'(src_a_s) * 34'(src_a_s);
    bb_s      = 34'(src_b_s) * 34'(src_b_s);
    s_wide_s  = aa_s + bb_s;
    sum32_s   = sat32(s_wide_s);
    sumsh_s   = s_wide_s[32:1];
    sq_s      = aa_s[31:0];
    thr_sel_s = thr_q[src_idx_s];
    acc_sum_s = {1'b0, acc_q} + {1'b0, sum32_s};
    case (src_op_s)
      F_SUM:   result_s = sum32_s;
      F_SUMSH: result_s = sumsh_s;
      F_SQ:    result_s = sq_s;
      F_CMPS:  result_s = {31'd0, (sum32_s > thr_sel_s)};
      F_CMPH:  result_s = {31'd0, (sumsh_s > thr_sel_s)};
      F_CMPQ:  result_s = {31'd0, (sq_s > thr_sel_s)};
      F_ACC:   result_s = sat32({1'b0, acc_sum_s});
      F_RDCLR: result_s = acc_q;
      default: result_s = rd_m_q;
    endcase
  end

  // Control FSM next-state, operand capture and architectural state update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    finish_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_s && (LAT == 1)) begin
          state_d  = S_DONE;
          finish_s = 1'b1;
        end else if (issue_s) begin
          state_d = S_BUSY;
          cnt_d   = 2'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (kill_s) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q == 2'(LAT - 1)) begin
          state_d  = S_DONE;
          cnt_d    = 2'd0;
          finish_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        if (kill_s && issue_s) begin
          state_d  = S_DONE;
          finish_s = 1'b1;
        end else if (kill_s) begin
          state_d = S_IDLE;
        end else if (UDI_run_m) begin
          state_d  = S_IDLE;
          commit_s = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (issue_s) begin
      op_d  = funct_s;
      idx_d = idx_e_s;
      rs_d  = UDI_rs_e;
      b_d   = UDI_rt_e[31 -: OPW];
    end else begin
      op_d  = op_q;
      idx_d = idx_q;
      rs_d  = rs_q;
      b_d   = b_q;
    end

    rd_m_d = finish_s ? result_s : rd_m_q;

    // rd_m_q already holds the new accumulator value by the time the ACC op commits.
    acc_d = acc_q;
    thr_d = thr_q;
    if (commit_s) begin
      case (op_q)
        F_ACC:   acc_d = rd_m_q;
        F_RDCLR: acc_d = 32'd0;
        F_WRTHR: thr_d[idx_q] = rs_q;
        default: acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers; reset aborts any operation in flight without committing it.
  always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
    if (!UDI_greset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 6'd0;
      idx_q   <= '0;
      rs_q    <= 32'd0;
      b_q     <= '0;
      rd_m_q  <= 32'd0;
      acc_q   <= 32'd0;
      for (int i = 0; i < NTHR; i++) begin
        thr_q[i] <= 32'hFFFF_FFFF;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      b_q     <= b_d;
      rd_m_q  <= rd_m_d;
      acc_q   <= acc_d;
      for (int i = 0; i < NTHR; i++) begin
        thr_q[i] <= thr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_udi_mag_cmp_pipe.sv
// Directed bench for udi_mag_cmp_pipe at OPW=16, NTHR=4, LAT=2: a vector table of issued ops
// followed by hand-written kill, reserved-instruction and mid-operation reset sequences.
module tb_udi_mag_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        irvalid = 1'b0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic        run = 1'b1;
  logic [31:0] rd_m;
  logic [4:0]  wrreg;
  logic        ri, stall, present, honor;

  int errors = 0;
  int checks = 0;

  udi_mag_cmp_pipe #(.OPW(16), .NTHR(4), .LAT(2)) dut (
    .UDI_gclk(clk), .UDI_greset_n(rst_n), .UDI_ir_e(ir), .UDI_irvalid_e(irvalid),
    .UDI_rs_e(rs), .UDI_rt_e(rt), .UDI_start_e(start), .UDI_kill_m(kill), .UDI_run_m(run),
    .UDI_rd_m(rd_m), .UDI_wrreg_e(wrreg), .UDI_ri_e(ri), .UDI_stall_m(stall),
    .UDI_present(present), .UDI_honor_cee(honor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [4:0]  idx;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] major, input logic [5:0] f,
                                        input logic [4:0] idx);
    mk_ir = {major, 5'd1, 5'd2, 5'd7, idx, f};
  endfunction

  // Issue one op at a negedge, optionally kill it in c1, and return rd_m seen in the DONE cycle.
  task automatic run_op(input string name, input logic [5:0] f, input logic [4:0] idx,
                        input logic [31:0] a, input logic [31:0] b, input bit kill_c1,
                        output logic [31:0] got, output int stalls);
    @(negedge clk);
    ir = mk_ir(6'd28, f, idx); irvalid = 1'b1; start = 1'b1; rs = a; rt = b;
    #1;
    chk({name, " wrreg"}, {27'd0, wrreg}, (f == 6'd19) ? 32'd0 : 32'd7);
    chk({name, " ri"}, {31'd0, ri}, 32'd0);
    @(posedge clk); #1;
    irvalid = 1'b0; start = 1'b0;
    stalls = 0;
    got = 32'hDEAD_BEEF;
    if (kill_c1) begin
      kill = 1'b1; run = 1'b1;
      @(negedge clk);
      chk({name, " stall during kill"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      kill = 1'b0;
      got = rd_m;
    end else begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (!stall) break;
        stalls++;
      end
      if (stall) chk({name, " done timeout"}, {31'd0, stall}, 32'd0);
      got = rd_m;
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] got;
  int          st;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{6'd16, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'd25});
    vecs.push_back('{6'd16, 5'd0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF});
    vecs.push_back('{6'd17, 5'd0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0001});
    vecs.push_back('{6'd18, 5'd0, 32'h0005_1234, 32'h0007_0000, 32'd25});
    vecs.push_back('{6'd19, 5'd2, 32'd24,        32'd0,        32'd25});
    vecs.push_back('{6'd20, 5'd2, 32'h0003_0000, 32'h0004_0000, 32'd1});
    vecs.push_back('{6'd20, 5'd1, 32'h0003_0000, 32'h0004_0000, 32'd0});
    vecs.push_back('{6'd21, 5'd2, 32'h0003_0000, 32'h0004_0000, 32'd0});
    vecs.push_back('{6'd22, 5'd2, 32'h0005_0000, 32'h0000_0000, 32'd1});
    vecs.push_back('{6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'd25});
    vecs.push_back('{6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'd50});
    vecs.push_back('{6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'd75});
    vecs.push_back('{6'd24, 5'd0, 32'd0,        32'd0,        32'd75});
    vecs.push_back('{6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'd25});
    vecs.push_back('{6'd24, 5'd0, 32'd0,        32'd0,        32'd25});
    vecs.push_back('{6'd23, 5'd0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF});
    vecs.push_back('{6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 32'hFFFF_FFFF});
    vecs.push_back('{6'd24, 5'd0, 32'd0,        32'd0,        32'hFFFF_FFFF});
    vecs.push_back('{6'd19, 5'd6, 32'd30,        32'd0,        32'hFFFF_FFFF});
    vecs.push_back('{6'd20, 5'd2, 32'h0003_0000, 32'h0004_0000, 32'd0});
    vecs.push_back('{6'd16, 5'd0, 32'h0001_0000, 32'h0000_0000, 32'd1});

    #12;
    chk("reset rd_m", rd_m, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("present/honor", {30'd0, present, honor}, 32'd3);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].idx, vecs[i].rs, vecs[i].rt, 1'b0, got, st);
      chk($sformatf("vec%0d rd", i), got, vecs[i].exp_rd);
      chk($sformatf("vec%0d stall cycles", i), st, 32'd1);
    end

    // Killed ACC leaves the accumulator and rd_m untouched.
    run_op("acc pre", 6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 1'b0, got, st);
    chk("acc pre rd", got, 32'd25);
    run_op("acc kill", 6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 1'b1, got, st);
    chk("acc kill rd_m held", got, 32'd25);
    @(negedge clk);
    chk("after kill idle", {31'd0, stall}, 32'd0);
    run_op("rdclr kill", 6'd24, 5'd0, 32'd0, 32'd0, 1'b0, got, st);
    chk("rdclr after kill", got, 32'd25);

    // Reserved funct and non-UDI major must not issue.
    @(negedge clk);
    ir = mk_ir(6'd28, 6'd25, 5'd0); irvalid = 1'b1; start = 1'b1;
    #1 chk("ri funct25", {31'd0, ri}, 32'd1);
    @(negedge clk);
    chk("ri no stall", {31'd0, stall}, 32'd0);
    ir = mk_ir(6'd0, 6'd16, 5'd0);
    #1 chk("non-udi ri", {31'd0, ri}, 32'd0);
    @(negedge clk);
    chk("non-udi no stall", {31'd0, stall}, 32'd0);
    irvalid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("ignored ops rd_m held", rd_m, 32'd25);

    // Build nonzero state, then reset in the middle of a busy op.
    run_op("acc before rst", 6'd23, 5'd0, 32'h0003_0000, 32'h0004_0000, 1'b0, got, st);
    chk("acc before rst rd", got, 32'd25);
    @(negedge clk);
    ir = mk_ir(6'd28, 6'd16, 5'd0); irvalid = 1'b1; start = 1'b1;
    rs = 32'h0003_0000; rt = 32'h0004_0000;
    @(posedge clk); #1;
    irvalid = 1'b0; start = 1'b0;
    chk("busy before rst", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst rd_m", rd_m, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("cmp after rst", 6'd20, 5'd2, 32'h0003_0000, 32'h0004_0000, 1'b0, got, st);
    chk("thr reset to max", got, 32'd0);
    run_op("rdclr after rst", 6'd24, 5'd0, 32'd0, 32'd0, 1'b0, got, st);
    chk("acc reset to 0", got, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
